mdio_phy_responder: RTL

- MDIO Clause-22 management responder: the PHY end of the MDC/MDIO link our management-master controller drives.
- Holds a 32x16 register file with a PHY-like default map.
- Used as a bench/loopback target for the management path and as an on-chip management slave.
- Runs on the system clock and oversamples MDC; no MDC-domain logic.

---
 rtl/mdio_phy_responder.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mdio_phy_responder.sv
// MDIO Clause-22 PHY-side responder: 32x16 register file, MDC oversampled on clk.
// Optional: define MDIO_PREAMBLE_SUPPRESS_EN so a completed frame lets the next one start after a single 1 bit.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter int unsigned PRE_MIN  = 32,
    parameter logic [15:0] ID1      = 16'h0022,
    parameter logic [15:0] ID2      = 16'h1619
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mdc,
    input  logic       mdio_in,
    output logic       mdio_out,
    output logic       mdio_z,
    output logic       wr_pulse,
    output logic [7:0] debug
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam bit SUPP_EN = 1'b1;
`else
    localparam bit SUPP_EN = 1'b0;
`endif
    localparam logic [5:0] PRE_MIN_W = 6'(PRE_MIN);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ST1     = 4'd1,
        OP      = 4'd2,
        PHYAD   = 4'd3,
        REGAD   = 4'd4,
        RTA     = 4'd5,
        RDATA   = 4'd6,
        WTA     = 4'd7,
        WDATA   = 4'd8,
        WCOMMIT = 4'd9
    } state_t;

    logic        mdc_meta_q, mdc_sync_q, mdc_prev_q;
    logic        mdio_meta_q, mdio_sync_q;
    logic        rise, fall;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  frame_q, frame_d;
    logic [5:0]  ones_q, ones_d;
    logic [5:0]  pre_need;
    logic [1:0]  op_q, op_d;
    logic [4:0]  phyad_q, phyad_d;
    logic [4:0]  regad_q, regad_d, regad_next;
    logic [15:0] shift_q, shift_d;
    logic        last_q, last_d;
    logic        supp_q, supp_d;
    logic        mdio_out_q, mdio_out_d;
    logic        mdio_z_q, mdio_z_d;
    logic        wr_pulse_q, wr_pulse_d;
    logic [15:0] regs_q [32];
    logic [15:0] regs_d [32];

    function automatic logic [15:0] reset_val(input logic [4:0] idx);
        case (idx)
            5'd0:    return 16'h3100;
            5'd1:    return 16'h786D;
            5'd2:    return ID1;
            5'd3:    return ID2;
            default: return '0;
        endcase
    endfunction

    // Synchronisers are not reset so a reset while MDC is high cannot fake a rise.
    always_ff @(posedge clk) begin
        mdc_meta_q  <= mdc;
        mdc_sync_q  <= mdc_meta_q;
        mdc_prev_q  <= mdc_sync_q;
        mdio_meta_q <= mdio_in;
        mdio_sync_q <= mdio_meta_q;
    end

    assign rise       = mdc_sync_q & ~mdc_prev_q;
    assign fall       = ~mdc_sync_q & mdc_prev_q;
    assign pre_need   = (SUPP_EN && supp_q) ? 6'd1 : PRE_MIN_W;
    assign regad_next = {regad_q[3:0], mdio_sync_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        ones_d     = ones_q;
        op_d       = op_q;
        phyad_d    = phyad_q;
        regad_d    = regad_q;
        shift_d    = shift_q;
        last_d     = last_q;
        supp_d     = supp_q;
        mdio_out_d = mdio_out_q;
        mdio_z_d   = mdio_z_q;
        wr_pulse_d = 1'b0;
        regs_d     = regs_q;

        case (state_q)
            IDLE: if (rise) begin
                if (mdio_sync_q) begin
                    ones_d = (ones_q == 6'd63) ? ones_q : ones_q + 6'd1;
                end else if (ones_q >= pre_need) begin
                    state_d = ST1;
                    supp_d  = 1'b0;
                end else begin
                    ones_d = '0;
                end
            end
            ST1: if (rise) begin
                if (mdio_sync_q) begin
                    state_d = OP;
                end else begin
                    state_d = IDLE;
                    ones_d  = '0;
                    supp_d  = 1'b0;
                end
            end
            OP: if (rise) begin
                op_d = {op_q[0], mdio_sync_q};
                if (cnt_q == 4'd1) begin
                    if (op_q[0] != mdio_sync_q) begin
                        state_d = PHYAD;
                    end else begin
                        state_d = IDLE;
                        ones_d  = '0;
                        supp_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            PHYAD: if (rise) begin
                phyad_d = {phyad_q[3:0], mdio_sync_q};
                if (cnt_q == 4'd4) state_d = REGAD;
                else cnt_d = cnt_q + 4'd1;
            end
            REGAD: if (rise) begin
                regad_d = regad_next;
                if (cnt_q != 4'd4) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (phyad_q != PHY_ADDR) begin
                    state_d = IDLE;
                    ones_d  = '0;
                    supp_d  = 1'b0;
                end else if (op_q == 2'b10) begin
                    state_d = RTA;
                    shift_d = regs_q[regad_next];
                end else begin
                    state_d = WTA;
                end
            end
            RTA: if (fall) begin
                if (cnt_q == 4'd0) begin
                    cnt_d = 4'd1;
                end else begin
                    mdio_z_d   = 1'b0;
                    mdio_out_d = 1'b0;
                    state_d    = RDATA;
                end
            end
            // last_q marks that all 16 bits are out; the next fall releases the pad.
            RDATA: if (fall) begin
                if (last_q) begin
                    mdio_z_d   = 1'b1;
                    mdio_out_d = 1'b1;
                    frame_d    = frame_q + 4'd1;
                    ones_d     = '0;
                    supp_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    mdio_out_d = shift_q[15];
                    shift_d    = {shift_q[14:0], 1'b0};
                    if (cnt_q == 4'd15) last_d = 1'b1;
                    else cnt_d = cnt_q + 4'd1;
                end
            end
            WTA: if (rise) begin
                if (cnt_q == 4'd1) state_d = WDATA;
                else cnt_d = cnt_q + 4'd1;
            end
            WDATA: if (rise) begin
                shift_d = {shift_q[14:0], mdio_sync_q};
                if (cnt_q == 4'd15) state_d = WCOMMIT;
                else cnt_d = cnt_q + 4'd1;
            end
            WCOMMIT: begin
                wr_pulse_d = 1'b1;
                frame_d    = frame_q + 4'd1;
                ones_d     = '0;
                supp_d     = 1'b1;
                state_d    = IDLE;
                if (regad_q == 5'd0 && shift_q[15]) begin
                    for (int unsigned i = 0; i < 32; i++) regs_d[i] = reset_val(5'(i));
                end else if (regad_q < 5'd1 || regad_q > 5'd3) begin
                    regs_d[regad_q] = shift_q;
                end
            end
            default: begin
                state_d = IDLE;
                ones_d  = '0;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d  = '0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            frame_q    <= '0;
            ones_q     <= '0;
            op_q       <= '0;
            phyad_q    <= '0;
            regad_q    <= '0;
            shift_q    <= '0;
            last_q     <= 1'b0;
            supp_q     <= 1'b0;
            mdio_out_q <= 1'b1;
            mdio_z_q   <= 1'b1;
            wr_pulse_q <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) regs_q[i] <= reset_val(5'(i));
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            ones_q     <= ones_d;
            op_q       <= op_d;
            phyad_q    <= phyad_d;
            regad_q    <= regad_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            supp_q     <= supp_d;
            mdio_out_q <= mdio_out_d;
            mdio_z_q   <= mdio_z_d;
            wr_pulse_q <= wr_pulse_d;
            for (int unsigned i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign mdio_out = mdio_out_q;
    assign mdio_z   = mdio_z_q;
    assign wr_pulse = wr_pulse_q;
    assign debug    = {state_q, frame_q};

endmodule
